inst_load_ctrl: RTL and testbench

INST_LOAD_CTRL -- requirements
Module: inst_load_ctrl

---
 rtl/inst_load_ctrl_if.sv | 31 +++
 rtl/inst_load_ctrl.sv | 166 ++++++++++++++++
 tb/tb_inst_load_ctrl.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_load_ctrl_if.sv
// Loader-side strobe bus and instruction-RAM write port of the load controller.
// The slave modport is the controller's view; master is the surrounding system.
interface inst_load_ctrl_if;
    logic [31:0] load_addr_i;
    logic [31:0] load_data_i;
    logic        load_we_i;
    logic [31:0] ram_addr_o;
    logic [31:0] ram_data_o;
    logic        ram_we_o;
    logic        ram_ready_i;

    modport slave (
        input  load_addr_i,
        input  load_data_i,
        input  load_we_i,
        input  ram_ready_i,
        output ram_addr_o,
        output ram_data_o,
        output ram_we_o
    );

    modport master (
        output load_addr_i,
        output load_data_i,
        output load_we_i,
        output ram_ready_i,
        input  ram_addr_o,
        input  ram_data_o,
        input  ram_we_o
    );
endinterface

// File: rtl/inst_load_ctrl.sv
// Buffers serial-loader words into instruction RAM and holds the core in reset
// until the end-of-load marker has arrived and every buffered word is written.
module inst_load_ctrl #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned IMEM_WORDS = 4096,
    parameter logic [31:0] END_ADDR   = 32'hFFFF_FFFC
) (
    input  logic                   clk,
    input  logic                   rst_n,
    inst_load_ctrl_if.slave        bus,
    output logic                   core_rst_n_o,
    output logic                   loading_o,
    output logic                   err_o,
    output logic [15:0]            word_cnt_o,
    output logic [31:0]            checksum_o
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PtrW:0] FullCount = (PtrW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        StLoad,
        StDrain,
        StRun
    } state_e;

    state_e state_q, state_d;

    logic [31:0]   addr_mem [FIFO_DEPTH];
    logic [31:0]   data_mem [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [PtrW:0]   count_q;

    logic        err_q;
    logic [15:0] word_cnt_q;
    logic [31:0] checksum_q;

    logic fifo_empty;
    logic fifo_full;
    logic pop;
    logic push;
    logic set_err;
    logic restart;
    logic addr_ok;
    logic is_end;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FullCount);
    assign pop        = !fifo_empty && bus.ram_ready_i;

    assign addr_ok = (bus.load_addr_i[1:0] == 2'b00) &&
                     ({2'b00, bus.load_addr_i[31:2]} < IMEM_WORDS);
    assign is_end  = (bus.load_addr_i == END_ADDR);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StLoad;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-cycle control decisions
    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        set_err = 1'b0;
        restart = 1'b0;
        case (state_q)
            StLoad: begin
                if (bus.load_we_i) begin
                    if (is_end) begin
                        state_d = StDrain;
                    end else if (!addr_ok || (fifo_full && !pop)) begin
                        set_err = 1'b1;
                    end else begin
                        push = 1'b1;
                    end
                end
            end
            StDrain: begin
                if (fifo_empty) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                // The FIFO is always empty here, so only the address can reject the word.
                if (bus.load_we_i && !is_end) begin
                    state_d = StLoad;
                    restart = 1'b1;
                    if (addr_ok) begin
                        push = 1'b1;
                    end else begin
                        set_err = 1'b1;
                    end
                end
            end
            default: begin
                state_d = StLoad;
            end
        endcase
    end

    // Storage is not reset; the occupancy counter alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr_q] <= bus.load_addr_i;
            data_mem[wr_ptr_q] <= bus.load_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q      <= 1'b0;
            word_cnt_q <= '0;
            checksum_q <= '0;
        end else begin
            err_q <= restart ? set_err : (err_q | set_err);
            if (restart) begin
                word_cnt_q <= '0;
                checksum_q <= '0;
            end else if (pop) begin
                if (word_cnt_q != 16'hFFFF) begin
                    word_cnt_q <= word_cnt_q + 16'd1;
                end
                checksum_q <= checksum_q + data_mem[rd_ptr_q];
            end
        end
    end

    // Head is masked while empty so the write port reads zero after reset.
    always_comb begin
        bus.ram_we_o   = !fifo_empty;
        bus.ram_addr_o = fifo_empty ? 32'h0 : addr_mem[rd_ptr_q];
        bus.ram_data_o = fifo_empty ? 32'h0 : data_mem[rd_ptr_q];
    end

    assign core_rst_n_o = (state_q == StRun);
    assign loading_o    = (state_q != StRun);
    assign err_o        = err_q;
    assign word_cnt_o   = word_cnt_q;
    assign checksum_o   = checksum_q;

endmodule

// File: tb/tb_inst_load_ctrl.sv
// Self-checking bench for inst_load_ctrl: table-driven single strobes plus
// hand-written multi-cycle sequences, with a queue scoreboard on the RAM port.
module tb_inst_load_ctrl;

    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned IMEM_WORDS = 4096;
    localparam logic [31:0] END_ADDR   = 32'hFFFF_FFFC;

    logic        clk;
    logic        rst_n;
    logic        core_rst_n_o;
    logic        loading_o;
    logic        err_o;
    logic [15:0] word_cnt_o;
    logic [31:0] checksum_o;

    inst_load_ctrl_if bus ();

    inst_load_ctrl #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .IMEM_WORDS (IMEM_WORDS),
        .END_ADDR   (END_ADDR)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus.slave),
        .core_rst_n_o (core_rst_n_o),
        .loading_o    (loading_o),
        .err_o        (err_o),
        .word_cnt_o   (word_cnt_o),
        .checksum_o   (checksum_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        bit          accept;
        bit          err;
    } vec_t;

    wr_t         exp_q[$];
    vec_t        vecs[7];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] exp_cnt;
    logic [31:0] exp_sum;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // A pop happens at the next rising edge whenever this holds at the falling edge.
    always @(negedge clk) begin
        if (rst_n && bus.ram_we_o && bus.ram_ready_i) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: got addr %h data %h, required no write",
                         bus.ram_addr_o, bus.ram_data_o);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", bus.ram_addr_o, e.addr);
                check("wr_data", bus.ram_data_o, e.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [31:0] a, input logic [31:0] d);
        bus.load_addr_i = a;
        bus.load_data_i = d;
        bus.load_we_i   = 1'b1;
        tick();
        bus.load_we_i   = 1'b0;
    endtask

    task automatic expect_wr(input logic [31:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
        if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
        exp_sum = exp_sum + d;
    endtask

    task automatic wait_drain(input int max_cycles);
        int i = 0;
        while ((exp_q.size() != 0 || bus.ram_we_o) && i < max_cycles) begin
            tick();
            i++;
        end
        if (exp_q.size() != 0 || bus.ram_we_o) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic wait_run(input int max_cycles);
        int i = 0;
        while (!core_rst_n_o && i < max_cycles) begin
            tick();
            i++;
        end
        check("run_reached", {31'b0, core_rst_n_o}, 32'd1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ram_we"},   {31'b0, bus.ram_we_o}, 32'd0);
        check({tag, "_ram_addr"}, bus.ram_addr_o, 32'd0);
        check({tag, "_ram_data"}, bus.ram_data_o, 32'd0);
        check({tag, "_core_rst"}, {31'b0, core_rst_n_o}, 32'd0);
        check({tag, "_loading"},  {31'b0, loading_o}, 32'd1);
        check({tag, "_err"},      {31'b0, err_o}, 32'd0);
        check({tag, "_cnt"},      {16'b0, word_cnt_o}, 32'd0);
        check({tag, "_sum"},      checksum_o, 32'd0);
    endtask

    initial begin
        vecs[0] = '{addr: 32'h0000_0010, data: 32'h0000_1000, accept: 1'b1, err: 1'b0};
        vecs[1] = '{addr: 32'h0000_3FFC, data: 32'hDEAD_BEEF, accept: 1'b1, err: 1'b0};
        vecs[2] = '{addr: 32'h0000_0014, data: 32'hFFFF_FFFF, accept: 1'b1, err: 1'b0};
        vecs[3] = '{addr: 32'h0000_0002, data: 32'h0000_0055, accept: 1'b0, err: 1'b1};
        vecs[4] = '{addr: IMEM_WORDS * 4, data: 32'h0000_0066, accept: 1'b0, err: 1'b1};
        vecs[5] = '{addr: 32'h0000_0001, data: 32'h0000_0077, accept: 1'b0, err: 1'b1};
        vecs[6] = '{addr: 32'h0000_0018, data: 32'h0000_0088, accept: 1'b1, err: 1'b1};

        bus.load_addr_i = '0;
        bus.load_data_i = '0;
        bus.load_we_i   = 1'b0;
        bus.ram_ready_i = 1'b1;
        rst_n   = 1'b0;
        exp_cnt = '0;
        exp_sum = '0;
        tick();
        tick();
        check_reset_vals("reset");
        rst_n = 1'b1;
        tick();

        // Basic load, end marker, drain to run.
        expect_wr(32'h0, 32'h11);
        strobe(32'h0, 32'h11);
        expect_wr(32'h4, 32'h22);
        strobe(32'h4, 32'h22);
        strobe(END_ADDR, 32'h0);
        wait_drain(20);
        wait_run(20);
        check("basic_cnt", {16'b0, word_cnt_o}, 32'd2);
        check("basic_sum", checksum_o, 32'h33);
        check("basic_loading", {31'b0, loading_o}, 32'd0);

        // Table: first vector re-enters LOAD from RUN, clearing the counters.
        exp_cnt = '0;
        exp_sum = '0;
        for (int i = 0; i < 7; i++) begin
            if (vecs[i].accept) expect_wr(vecs[i].addr, vecs[i].data);
            strobe(vecs[i].addr, vecs[i].data);
            tick();
            wait_drain(10);
            check($sformatf("vec%0d_err", i), {31'b0, err_o}, {31'b0, vecs[i].err});
            check($sformatf("vec%0d_cnt", i), {16'b0, word_cnt_o}, {16'b0, exp_cnt});
            check($sformatf("vec%0d_sum", i), checksum_o, exp_sum);
        end
        strobe(END_ADDR, 32'h0);
        wait_run(20);
        check("run_err_kept", {31'b0, err_o}, 32'd1);
        strobe(END_ADDR, 32'h0);
        check("run_end_ignored", {31'b0, core_rst_n_o}, 32'd1);

        // Re-entry from RUN.
        exp_cnt = '0;
        exp_sum = '0;
        expect_wr(32'h8, 32'hAB);
        strobe(32'h8, 32'hAB);
        check("reent_core_rst", {31'b0, core_rst_n_o}, 32'd0);
        check("reent_err", {31'b0, err_o}, 32'd0);
        check("reent_we_latency", {31'b0, bus.ram_we_o}, 32'd1);
        wait_drain(10);
        check("reent_cnt", {16'b0, word_cnt_o}, 32'd1);
        check("reent_sum", checksum_o, 32'hAB);
        strobe(END_ADDR, 32'h0);
        wait_run(20);

        // Overflow with RAM stalled: fifth strobe dropped.
        bus.ram_ready_i = 1'b0;
        exp_cnt = '0;
        exp_sum = '0;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) expect_wr(32'h20 + 4 * i, 32'hA1 + i);
            strobe(32'h20 + 4 * i, 32'hA1 + i);
        end
        tick();
        tick();
        check("ovf_err", {31'b0, err_o}, 32'd1);
        check("ovf_head_addr", bus.ram_addr_o, 32'h20);
        check("ovf_head_data", bus.ram_data_o, 32'hA1);
        check("ovf_cnt_stalled", {16'b0, word_cnt_o}, 32'd0);
        bus.ram_ready_i = 1'b1;
        wait_drain(20);
        check("ovf_cnt", {16'b0, word_cnt_o}, {16'b0, exp_cnt});
        check("ovf_sum", checksum_o, exp_sum);
        strobe(END_ADDR, 32'h0);
        wait_run(20);

        // Full FIFO with a pop and a push in the same cycle.
        bus.ram_ready_i = 1'b0;
        exp_cnt = '0;
        exp_sum = '0;
        for (int i = 0; i < 4; i++) begin
            expect_wr(32'h40 + 4 * i, 32'hB0 + i);
            strobe(32'h40 + 4 * i, 32'hB0 + i);
        end
        bus.ram_ready_i = 1'b1;
        expect_wr(32'h50, 32'hB4);
        strobe(32'h50, 32'hB4);
        check("full_pop_push_err", {31'b0, err_o}, 32'd0);
        wait_drain(20);
        check("full_pop_push_cnt", {16'b0, word_cnt_o}, 32'd5);
        check("full_pop_push_sum", checksum_o, exp_sum);
        strobe(END_ADDR, 32'h0);
        wait_run(20);

        // Reset during DRAIN with three words pending.
        bus.ram_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            expect_wr(32'h60 + 4 * i, 32'hC0 + i);
            strobe(32'h60 + 4 * i, 32'hC0 + i);
        end
        strobe(END_ADDR, 32'h0);
        tick();
        check("drain_loading", {31'b0, loading_o}, 32'd1);
        check("drain_core_rst", {31'b0, core_rst_n_o}, 32'd0);
        check("drain_we", {31'b0, bus.ram_we_o}, 32'd1);
        rst_n = 1'b0;
        tick();
        exp_q.delete();
        check_reset_vals("mid_drain_reset");
        rst_n = 1'b1;
        bus.ram_ready_i = 1'b1;
        repeat (5) tick();
        check("post_reset_we", {31'b0, bus.ram_we_o}, 32'd0);
        check("post_reset_cnt", {16'b0, word_cnt_o}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout, required completion");
        $fatal(1, "bench timeout");
    end

endmodule
